renkon_linebuf_window: RTL and testbench
========================================

// Module: renkon_linebuf_window
// PURPOSE
//  Multi-line sliding-column buffer feeding the renkon convolution datapath.
//  - Accepts a raster pixel stream, one pixel per in_valid cycle.
//  - Keeps the previous LINES-1 image rows in internal line RAMs.
//  - Emits one LINES-pixel vertical column per accepted pixel once LINES-1 rows are stored.
//  - Generalises the single line buffer: runtime image width, LINES rows, window assembly.
// PARAMETERS
//  DWIDTH   16  pixel width in bits (signed)
//  BUFSIZE  8   log2 of max image width; each line RAM holds 2**BUFSIZE words
//  LINES    3   window height (>=2); LINES-1 line RAMs are instantiated
// PORTS
//  clk        in   1               clock, rising edge
//  xrst       in   1               asynchronous reset, active-low
//  clear      in   1               sync frame start: zero counters, latch img_width
//  img_width  in   BUFSIZE+1       pixels per row, legal range 1..2**BUFSIZE, sampled on clear
//  in_valid   in   1               in_data valid this cycle; no backpressure
//  in_data    in   DWIDTH          signed pixel, raster order
//  out_valid  out  1               out_data/out_col/out_last valid this cycle
//  out_data   out  LINES*DWIDTH    column; lane k = bits [k*DWIDTH +: DWIDTH]
//  out_col    out  BUFSIZE         column index of the emitted column
//  out_last   out  1               emitted column is the last one of its row
//  cfg_err    out  1               sticky: clear seen with img_width==0 or >2**BUFSIZE
// BEHAVIOUR
//  - Reset (xrst=0): out_valid, out_data, out_col, out_last, cfg_err = 0.
//    Col/row counters and write pointer = 0; width register = 2**BUFSIZE.
//    RAM contents are undefined after reset.
//  - clear: same register effect as reset, except the width register loads img_width.
//    If img_width is illegal, the width register loads 2**BUFSIZE and cfg_err sets.
//    cfg_err is cleared only by xrst. RAM contents are untouched.
//    clear has priority over a coincident in_valid; that pixel is dropped.
//  - Counters:
//    - col increments per accepted pixel and wraps width-1 -> 0.
//    - On wrap, wp advances modulo LINES-1 and rowcnt increments, saturating at LINES-1.
//  - Line RAMs:
//    - On each accepted pixel, all LINES-1 RAMs read address col.
//    - RAM[wp] is written with in_data at address col in the same cycle.
//    - Read-before-write: the read returns the old word. Read data is registered (1 cycle).
//  - Latency: exactly 1 cycle. in_valid at cycle t gives out_valid at t+1, and only if
//    rowcnt>=LINES-1 at t. in_data is delayed one cycle to align with the RAM outputs.
//  - Lane order:
//    - lane LINES-1 = current pixel (row r).
//    - lane k = row r-(LINES-1-k); lane 0 = oldest row.
//    - RAM mapping: lane j (0..LINES-2) comes from RAM[(wp+j) mod (LINES-1)] as sampled at t.
//  - Output hold: when out_valid=0, out_data/out_col/out_last hold their last values.
//  - Gaps: in_valid may drop for any number of cycles. State is frozen and no output is made.
//  - Boundaries:
//    - Width 1: every pixel ends a row, so out_last=1 on every output.
//    - Width 2**BUFSIZE uses every RAM word.
//    - Rows are unbounded: no frame-end detection; the next frame begins with clear.
// TESTING
//  1. LINES=3, width 4, feed px=16*row+col for rows 0..3.
//     -> no out_valid during rows 0-1.
//     -> row 2 col 0 gives out_data lanes {0x00,0x10,0x20}, out_col=0.
//     -> row 3 col 3 gives {0x13,0x23,0x33}, out_last=1.
//  2. Same stream with in_valid toggling 1,0,0,1 pattern.
//     -> output sequence identical to test 1, each output 1 cycle after its input.
//  3. Mid row 2 (col 2), pulse clear with img_width=2, then feed 3 new rows.
//     -> no output until new row 2; lanes then come from the new frame only.
//  4. clear with img_width=0, then clear with 2**BUFSIZE+1.
//     -> cfg_err=1 after each; width acts as 2**BUFSIZE.
//     -> cfg_err stays 1 until xrst.
//  5. Assert xrst mid row 3 while in_valid=1.
//     -> out_valid=0 immediately (async); after release, 2 full rows are needed before output.
//  6. img_width=1, LINES=3, feed 5,6,7,8.
//     -> outputs {5,6,7} then {6,7,8}, both with out_last=1, out_col=0.

Source files
------------

// File: rtl/renkon_linebuf_window_if.sv
// Purpose: pixel-stream / column-window bus for renkon_linebuf_window.
// Signals:
//   clear, img_width         frame start and runtime row width (sampled on clear)
//   in_valid, in_data        raster pixel stream, no backpressure
//   out_valid, out_data      LINES-pixel column, lane 0 = oldest row
//   out_col, out_last        column index of the emitted column, last-of-row flag
//   cfg_err                  sticky illegal-width flag
// Modports: master drives the pixel stream, slave is the line buffer.
interface renkon_linebuf_window_if #(
    parameter int unsigned DWIDTH  = 16,
    parameter int unsigned BUFSIZE = 8,
    parameter int unsigned LINES   = 3
);
    logic                          clear;
    logic [BUFSIZE:0]              img_width;
    logic                          in_valid;
    logic signed [DWIDTH-1:0]      in_data;
    logic                          out_valid;
    logic [LINES*DWIDTH-1:0]       out_data;
    logic [BUFSIZE-1:0]            out_col;
    logic                          out_last;
    logic                          cfg_err;

    modport master (
        output clear, img_width, in_valid, in_data,
        input  out_valid, out_data, out_col, out_last, cfg_err
    );

    modport slave (
        input  clear, img_width, in_valid, in_data,
        output out_valid, out_data, out_col, out_last, cfg_err
    );
endinterface

// File: rtl/renkon_linebuf_window.sv
// Purpose: multi-line sliding-column buffer. Stores the previous LINES-1 rows
// in line RAMs and emits one LINES-pixel vertical column per accepted pixel
// once LINES-1 rows of the current frame have been stored.
// Ports:
//   clk   rising-edge clock
//   xrst  asynchronous active-low reset
//   bus   renkon_linebuf_window_if slave (pixel stream in, column out)
module renkon_linebuf_window #(
    parameter int unsigned DWIDTH  = 16,
    parameter int unsigned BUFSIZE = 8,
    parameter int unsigned LINES   = 3
) (
    input  logic                    clk,
    input  logic                    xrst,
    renkon_linebuf_window_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** BUFSIZE;
    localparam int unsigned NRAM  = LINES - 1;
    localparam int unsigned WPW   = (NRAM > 1) ? $clog2(NRAM) : 1;
    localparam int unsigned RCW   = $clog2(LINES);
    localparam int unsigned WW    = BUFSIZE + 1;
    localparam int unsigned OW    = LINES * DWIDTH;

    localparam logic [WW-1:0]  MAX_WIDTH = WW'(DEPTH);
    localparam logic [WPW-1:0] WP_LAST   = WPW'(NRAM - 1);
    localparam logic [RCW-1:0] ROW_FULL  = RCW'(NRAM);

    logic [DWIDTH-1:0]  mem [NRAM][DEPTH];

    logic [WW-1:0]      width_q;
    logic [BUFSIZE-1:0] col_q;
    logic [WPW-1:0]     wp_q;
    logic [RCW-1:0]     rowcnt_q;

    logic               out_valid_q;
    logic [OW-1:0]      out_data_q;
    logic [BUFSIZE-1:0] out_col_q;
    logic               out_last_q;
    logic               cfg_err_q;

    logic               accept_c;
    logic               last_c;
    logic               emit_c;
    logic               width_ok_c;
    logic [WPW-1:0]     sel_c [NRAM];
    logic [OW-1:0]      col_data_c;

    // Handshake decode; clear wins over a coincident pixel.
    always_comb begin
        accept_c   = bus.in_valid && !bus.clear;
        last_c     = ({1'b0, col_q} == (width_q - WW'(1)));
        emit_c     = accept_c && (rowcnt_q == ROW_FULL);
        width_ok_c = (bus.img_width != '0) && (bus.img_width <= MAX_WIDTH);
    end

    // Lane j reads RAM[(wp+j) mod NRAM]; RAM[wp] holds the oldest stored row.
    always_comb begin
        int unsigned s;
        s     = 0;
        sel_c = '{default: '0};
        for (int unsigned j = 0; j < NRAM; j++) begin
            s = 32'(wp_q) + j;
            if (s >= NRAM) begin
                s = s - NRAM;
            end
            sel_c[j] = WPW'(s);
        end
    end

    // Column assembly: old words from the RAMs, current pixel on the top lane.
    always_comb begin
        col_data_c = '0;
        for (int unsigned j = 0; j < NRAM; j++) begin
            col_data_c[j*DWIDTH +: DWIDTH] = mem[sel_c[j]][col_q];
        end
        col_data_c[NRAM*DWIDTH +: DWIDTH] = bus.in_data;
    end

    // Line RAM write; the read above samples the old word (read-before-write).
    always_ff @(posedge clk) begin
        if (accept_c) begin
            mem[wp_q][col_q] <= bus.in_data;
        end
    end

    // Column/row counters, write pointer and width register.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            width_q  <= MAX_WIDTH;
            col_q    <= '0;
            wp_q     <= '0;
            rowcnt_q <= '0;
        end else if (bus.clear) begin
            width_q  <= width_ok_c ? bus.img_width : MAX_WIDTH;
            col_q    <= '0;
            wp_q     <= '0;
            rowcnt_q <= '0;
        end else if (accept_c) begin
            if (last_c) begin
                col_q <= '0;
                wp_q  <= (wp_q == WP_LAST) ? '0 : wp_q + WPW'(1);
                if (rowcnt_q != ROW_FULL) begin
                    rowcnt_q <= rowcnt_q + RCW'(1);
                end
            end else begin
                col_q <= col_q + BUFSIZE'(1);
            end
        end
    end

    // Registered outputs; payload holds while nothing is emitted.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else if (bus.clear) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
            if (!width_ok_c) begin
                cfg_err_q <= 1'b1;
            end
        end else begin
            out_valid_q <= emit_c;
            if (emit_c) begin
                out_data_q <= col_data_c;
                out_col_q  <= col_q;
                out_last_q <= last_c;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_col   = out_col_q;
    assign bus.out_last  = out_last_q;
    assign bus.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_renkon_linebuf_window.sv
// Purpose: self-checking bench for renkon_linebuf_window. A row-history model
// predicts every output cycle; directed scenarios add literal expectations.
module tb_renkon_linebuf_window;
    localparam int unsigned DW    = 16;
    localparam int unsigned BS    = 8;
    localparam int unsigned LN    = 3;
    localparam int          DEPTH = 256;

    logic clk = 1'b0;
    logic xrst;
    logic chk_en;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    renkon_linebuf_window_if #(.DWIDTH(DW), .BUFSIZE(BS), .LINES(LN)) bus ();

    renkon_linebuf_window #(.DWIDTH(DW), .BUFSIZE(BS), .LINES(LN)) dut (
        .clk  (clk),
        .xrst (xrst),
        .bus  (bus)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: image rows kept by absolute row number (mod 8), column read straight out.
    logic [DW-1:0]    hist [8][DEPTH];
    int               m_width, m_col, m_row, e_col;
    logic             e_valid, e_last, e_err;
    logic [LN*DW-1:0] e_data;

    always @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            m_width = DEPTH; m_col = 0; m_row = 0;
            e_valid = 1'b0; e_data = '0; e_col = 0; e_last = 1'b0; e_err = 1'b0;
        end else begin
            e_valid = 1'b0;
            if (bus.clear) begin
                if (int'(bus.img_width) >= 1 && int'(bus.img_width) <= DEPTH) begin
                    m_width = int'(bus.img_width);
                end else begin
                    m_width = DEPTH;
                    e_err   = 1'b1;
                end
                m_col = 0; m_row = 0; e_data = '0; e_col = 0; e_last = 1'b0;
            end else if (bus.in_valid) begin
                hist[m_row % 8][m_col] = bus.in_data;
                if (m_row >= LN - 1) begin
                    e_valid = 1'b1;
                    for (int k = 0; k < LN; k++) begin
                        e_data[k*DW +: DW] = hist[(m_row - (LN - 1 - k)) % 8][m_col];
                    end
                    e_col  = m_col;
                    e_last = (m_col == m_width - 1);
                end
                m_col++;
                if (m_col == m_width) begin
                    m_col = 0;
                    m_row++;
                end
            end
        end
        #1;
        if (chk_en) begin
            chk("out_valid", 64'(bus.out_valid), 64'(e_valid));
            chk("out_data",  64'(bus.out_data),  64'(e_data));
            chk("out_col",   64'(bus.out_col),   64'(e_col[BS-1:0]));
            chk("out_last",  64'(bus.out_last),  64'(e_last));
            chk("cfg_err",   64'(bus.cfg_err),   64'(e_err));
        end
    end

    task automatic drive(input logic v, input logic [DW-1:0] d);
        @(negedge clk);
        bus.clear    = 1'b0;
        bus.in_valid = v;
        bus.in_data  = d;
    endtask

    // Frame start; a random coincident pixel must be dropped.
    task automatic do_clear(input int w);
        @(negedge clk);
        bus.clear     = 1'b1;
        bus.img_width = (BS+1)'(w);
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.in_data   = DW'($urandom);
    endtask

    // Call right after driving a pixel: checks the column it produces.
    task automatic expect_col(input string name, input logic [LN*DW-1:0] d,
                              input int c, input logic l);
        @(posedge clk);
        #2;
        chk({name, "_valid"}, 64'(bus.out_valid), 64'(1));
        chk({name, "_data"},  64'(bus.out_data),  64'(d));
        chk({name, "_col"},   64'(bus.out_col),   64'(c));
        chk({name, "_last"},  64'(bus.out_last),  64'(l));
    endtask

    task automatic feed_random(input int n, input int pct);
        for (int i = 0; i < n; i++) begin
            drive(1'($urandom_range(0, 99) < pct), DW'($urandom));
        end
    endtask

    initial begin
        bus.clear = 1'b0; bus.img_width = '0; bus.in_valid = 1'b0; bus.in_data = '0;
        chk_en = 1'b0;
        xrst   = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_data",  64'(bus.out_data),  64'(0));
        chk("rst_col",   64'(bus.out_col),   64'(0));
        chk("rst_last",  64'(bus.out_last),  64'(0));
        chk("rst_err",   64'(bus.cfg_err),   64'(0));
        chk_en = 1'b1;
        @(negedge clk);
        xrst = 1'b1;

        // Width 4, px = 16*row + col.
        do_clear(4);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                drive(1'b1, DW'(16 * r + c));
                if (r == 2 && c == 0) expect_col("t1_r2c0", 48'h0020_0010_0000, 0, 1'b0);
                if (r == 3 && c == 3) expect_col("t1_r3c3", 48'h0033_0023_0013, 3, 1'b1);
            end
        end

        // Same stream with idle gaps.
        do_clear(4);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                drive(1'b1, DW'(16 * r + c));
                if (r == 2 && c == 0) expect_col("t2_r2c0", 48'h0020_0010_0000, 0, 1'b0);
                drive(1'b0, DW'($urandom));
                drive(1'b0, DW'($urandom));
            end
        end

        // Clear in mid row 2, restart at width 2.
        do_clear(4);
        for (int p = 0; p < 10; p++) drive(1'b1, DW'(16 * (p / 4) + (p % 4)));
        do_clear(2);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++) begin
                drive(1'b1, DW'(256 + 16 * r + c));
                if (r == 2 && c == 0) expect_col("t3_c0", 48'h0120_0110_0100, 0, 1'b0);
                if (r == 2 && c == 1) expect_col("t3_c1", 48'h0121_0111_0101, 1, 1'b1);
            end
        end

        // Illegal widths: sticky error, width falls back to 256.
        do_clear(0);
        drive(1'b0, '0);
        chk("t4_err_w0", 64'(bus.cfg_err), 64'(1));
        feed_random(2 * DEPTH + 20, 90);
        do_clear(DEPTH + 1);
        drive(1'b0, '0);
        chk("t4_err_w257", 64'(bus.cfg_err), 64'(1));
        feed_random(2 * DEPTH + 10, 100);
        do_clear(5);
        drive(1'b0, '0);
        chk("t4_err_sticky", 64'(bus.cfg_err), 64'(1));
        feed_random(20, 100);

        // Async reset in mid row 3 with a pixel in flight.
        do_clear(6);
        for (int p = 0; p < 21; p++) drive(1'b1, DW'($urandom));
        @(posedge clk);
        #3;
        xrst = 1'b0;
        #1;
        chk("t5_async_valid", 64'(bus.out_valid), 64'(0));
        chk("t5_async_err",   64'(bus.cfg_err),   64'(0));
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        xrst = 1'b1;
        feed_random(2 * DEPTH + 8, 100);

        // Width 1: every pixel is a row.
        do_clear(1);
        drive(1'b1, DW'(5));
        drive(1'b1, DW'(6));
        drive(1'b1, DW'(7));
        expect_col("t6_a", 48'h0007_0006_0005, 0, 1'b1);
        drive(1'b1, DW'(8));
        expect_col("t6_b", 48'h0008_0007_0006, 0, 1'b1);

        // Random frames.
        for (int f = 0; f < 40; f++) begin
            int w;
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      w = DEPTH;
            else if (sel == 1) w = int'($urandom_range(0, 1)) * (DEPTH + 1 + int'($urandom_range(0, 200)));
            else               w = int'($urandom_range(1, 12));
            do_clear(w);
            if (w == DEPTH || w == 0 || w > DEPTH) feed_random(2 * DEPTH + 40, 95);
            else feed_random(int'($urandom_range(20, 200)), 70);
        end

        drive(1'b0, '0);
        repeat (3) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
